// File: rtl/sent_tx_frame_builder.sv
// SENT transmit frame sequencer: pops fast-channel words, packs them into data nibbles, appends CRC4
// and streams typed nibbles, carrying the short serial message one bit per frame in the status nibble.
module sent_tx_frame_builder #(
  parameter bit         PAUSE_EN = 1'b1,
  parameter logic [3:0] CRC_SEED = 4'b0101
) (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        tx_enable,
  input  logic [2:0]  frame_format,
  input  logic [1:0]  status_in,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [11:0] fifo_rd_data,
  input  logic        ser_valid,
  input  logic [3:0]  ser_id,
  input  logic [7:0]  ser_data,
  output logic        nib_valid,
  input  logic        nib_ready,
  output logic [1:0]  nib_type,
  output logic [3:0]  nib_data,
  output logic        frame_done,
  output logic        ser_msg_done,
  output logic        fmt_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAITRD, S_CRC, S_SYNC, S_STATUS, S_DATA, S_CRCN, S_PAUSE
  } state_t;

  state_t      state;
  logic [2:0]  fmt;
  logic [1:0]  status_q;
  logic [11:0] w0;
  logic [11:0] w1;
  logic        second_word;
  logic [3:0]  crc;
  logic [2:0]  idx;
  logic [3:0]  ser_cnt;
  logic [15:0] ser_sh;
  logic        msg_active;

  logic        fmt_legal;
  logic        accept;
  logic        frame_end;
  logic [2:0]  last_idx;
  logic [3:0]  data_nib;
  logic [3:0]  crc_nib;
  logic [3:0]  status_nib;
  logic [3:0]  ser_crc;

  // Bit-serial CRC4 (x^4+x^3+x^2+1) over one nibble, MSB first.
  function automatic logic [3:0] crc_step(input logic [3:0] crc_in, input logic [3:0] nib);
    logic [3:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ nib[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'hD : 4'h0);
    end
    return c;
  endfunction

  assign fmt_legal  = (frame_format == 3'd1) || (frame_format == 3'd2) || (frame_format == 3'd7);
  assign last_idx   = (fmt == 3'd2) ? 3'd2 : 3'd5;
  assign accept     = nib_valid && nib_ready;
  assign frame_end  = accept && (((state == S_CRCN) && !PAUSE_EN) || (state == S_PAUSE));
  assign ser_crc    = crc_step(crc_step(crc_step(crc_step(CRC_SEED, ser_id), ser_data[7:4]),
                                        ser_data[3:0]), 4'h0);
  assign status_nib = {msg_active && (ser_cnt == 4'd0), msg_active && ser_sh[15], status_q};
  // The index runs one past the last data nibble to feed the augmenting zero nibble.
  assign crc_nib    = (idx > last_idx) ? 4'h0 : data_nib;

  always_comb begin
    data_nib = 4'h0;
    case (idx)
      3'd0:    data_nib = w0[11:8];
      3'd1:    data_nib = w0[7:4];
      3'd2:    data_nib = w0[3:0];
      3'd3:    data_nib = (fmt == 3'd7) ? w1[11:8] : w1[3:0];
      3'd4:    data_nib = (fmt == 3'd7) ? w1[3:0]  : w1[7:4];
      3'd5:    data_nib = (fmt == 3'd7) ? w1[7:4]  : w1[11:8];
      default: data_nib = 4'h0;
    endcase
  end

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      state        <= S_IDLE;
      fmt          <= 3'd0;
      status_q     <= 2'd0;
      w0           <= 12'h0;
      w1           <= 12'h0;
      second_word  <= 1'b0;
      crc          <= 4'h0;
      idx          <= 3'd0;
      ser_cnt      <= 4'd0;
      ser_sh       <= 16'h0;
      msg_active   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      nib_valid    <= 1'b0;
      nib_type     <= 2'd0;
      nib_data     <= 4'h0;
      frame_done   <= 1'b0;
      ser_msg_done <= 1'b0;
      fmt_err      <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      ser_msg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_enable && !fifo_empty) begin
            if (fmt_legal) begin
              fmt         <= frame_format;
              status_q    <= status_in;
              crc         <= CRC_SEED;
              idx         <= 3'd0;
              second_word <= 1'b0;
              fifo_rd_en  <= 1'b1;
              state       <= S_FETCH;
              if (ser_cnt == 4'd0) begin
                msg_active <= ser_valid;
                ser_sh     <= ser_valid ? {ser_id, ser_data, ser_crc} : 16'h0;
              end
            end else begin
              fmt_err <= 1'b1;
            end
          end
        end
        // The pop strobe is decided a cycle ahead, so FETCH with fifo_rd_en high is the pop cycle.
        S_FETCH: begin
          if (fifo_rd_en) begin
            fifo_rd_en <= 1'b0;
            state      <= S_WAITRD;
          end else if (!fifo_empty) begin
            fifo_rd_en <= 1'b1;
          end
        end
        S_WAITRD: begin
          if (!second_word) begin
            w0 <= fifo_rd_data;
            if (fmt != 3'd2) begin
              second_word <= 1'b1;
              fifo_rd_en  <= !fifo_empty;
              state       <= S_FETCH;
            end else begin
              state <= S_CRC;
            end
          end else begin
            w1    <= fifo_rd_data;
            state <= S_CRC;
          end
        end
        S_CRC: begin
          crc <= crc_step(crc, crc_nib);
          if (idx == last_idx + 3'd1) begin
            idx       <= 3'd0;
            nib_valid <= 1'b1;
            nib_type  <= 2'd0;
            nib_data  <= 4'h0;
            state     <= S_SYNC;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_SYNC: begin
          if (accept) begin
            nib_valid <= 1'b0;
            state     <= S_STATUS;
          end else if (!nib_valid) begin
            nib_valid <= 1'b1;
            nib_type  <= 2'd0;
            nib_data  <= 4'h0;
          end
        end
        S_STATUS: begin
          if (accept) begin
            nib_valid <= 1'b0;
            idx       <= 3'd0;
            state     <= S_DATA;
          end else if (!nib_valid) begin
            nib_valid <= 1'b1;
            nib_type  <= 2'd1;
            nib_data  <= status_nib;
          end
        end
        S_DATA: begin
          if (accept) begin
            nib_valid <= 1'b0;
            if (idx == last_idx) begin
              state <= S_CRCN;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (!nib_valid) begin
            nib_valid <= 1'b1;
            nib_type  <= 2'd1;
            nib_data  <= data_nib;
          end
        end
        S_CRCN: begin
          if (accept) begin
            nib_valid <= 1'b0;
            state     <= PAUSE_EN ? S_PAUSE : S_IDLE;
          end else if (!nib_valid) begin
            nib_valid <= 1'b1;
            nib_type  <= 2'd2;
            nib_data  <= crc;
          end
        end
        S_PAUSE: begin
          if (accept) begin
            nib_valid <= 1'b0;
            state     <= S_IDLE;
          end else if (!nib_valid) begin
            nib_valid <= 1'b1;
            nib_type  <= 2'd3;
            nib_data  <= 4'h0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (frame_end) begin
        frame_done <= 1'b1;
        ser_cnt    <= ser_cnt + 4'd1;
        if (msg_active) begin
          ser_sh <= {ser_sh[14:0], 1'b0};
          if (ser_cnt == 4'd15) begin
            ser_msg_done <= 1'b1;
            msg_active   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_builder.sv
// Scoreboard bench for sent_tx_frame_builder: directed frames push hand-computed nibbles into a
// queue and a monitor pops and compares each accepted nibble.
module tb_sent_tx_frame_builder;

  logic        clk_rx = 1'b0;
  logic        reset_rx;
  logic        tx_enable;
  logic [2:0]  frame_format;
  logic [1:0]  status_in;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [11:0] fifo_rd_data = 12'h0;
  logic        ser_valid;
  logic [3:0]  ser_id;
  logic [7:0]  ser_data;
  logic        nib_valid;
  logic        nib_ready;
  logic [1:0]  nib_type;
  logic [3:0]  nib_data;
  logic        frame_done;
  logic        ser_msg_done;
  logic        fmt_err;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] d;
  } nib_t;

  nib_t        exp_q[$];
  nib_t        exp_n;
  nib_t        held_nib;
  logic        held = 1'b0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          acc_cnt = 0;
  int          fd_cnt = 0;
  int          smd_cnt = 0;
  int          smd_at = 0;
  int          rd_cnt = 0;
  int          hold_cnt = 0;
  logic [11:0] fifo_mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [15:0] ser_bits = 16'h3A53;

  always #5 clk_rx = ~clk_rx;

  sent_tx_frame_builder dut (
    .clk_rx       (clk_rx),
    .reset_rx     (reset_rx),
    .tx_enable    (tx_enable),
    .frame_format (frame_format),
    .status_in    (status_in),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .ser_valid    (ser_valid),
    .ser_id       (ser_id),
    .ser_data     (ser_data),
    .nib_valid    (nib_valid),
    .nib_ready    (nib_ready),
    .nib_type     (nib_type),
    .nib_data     (nib_data),
    .frame_done   (frame_done),
    .ser_msg_done (ser_msg_done),
    .fmt_err      (fmt_err)
  );

  // Synchronous FIFO model: data appears the cycle after the pop strobe.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk_rx) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= fifo_mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor samples just after the falling edge, where DUT outputs and bench inputs are settled.
  always begin
    @(negedge clk_rx);
    #1;
    if (!reset_rx) begin
      if (frame_done) fd_cnt++;
      if (ser_msg_done) begin
        smd_cnt++;
        smd_at = fd_cnt;
      end
      if (fifo_rd_en) begin
        rd_cnt++;
        check_output("pop_when_nonempty", 32'(fifo_empty), 32'd0);
      end
      if (held)
        check_output("hold_stable", {25'd0, nib_valid, nib_type, nib_data}, {25'd0, 1'b1, held_nib});
      held = 1'b0;
      if (nib_valid && nib_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("[TB] FAIL unexpected_nibble: got type %0d data 0x%0h, expected none", nib_type, nib_data);
        end else begin
          exp_n = exp_q.pop_front();
          check_output("nibble", {26'd0, nib_type, nib_data}, {26'd0, exp_n});
        end
      end else if (nib_valid) begin
        held     = 1'b1;
        held_nib = {nib_type, nib_data};
        hold_cnt++;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic push_word(input logic [11:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic expect_frame(input logic [3:0] st, input logic [23:0] nibs, input int n,
                              input logic [3:0] crc);
    exp_q.push_back(nib_t'({2'd0, 4'h0}));
    exp_q.push_back(nib_t'({2'd1, st}));
    for (int i = 0; i < n; i++) exp_q.push_back(nib_t'({2'd1, nibs[23-4*i -: 4]}));
    exp_q.push_back(nib_t'({2'd2, crc}));
    exp_q.push_back(nib_t'({2'd3, 4'h0}));
  endtask

  task automatic apply_stimulus(input logic [2:0] fmt, input logic [1:0] st);
    frame_format = fmt;
    status_in    = st;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = fd_cnt + n;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_rx);
      #2;
      if (fd_cnt >= target) break;
    end
    check_output("frames_done", fd_cnt, target);
  endtask

  task automatic wait_acc(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_rx);
      #2;
      if (acc_cnt >= target) break;
    end
    check_output("nibbles_accepted", acc_cnt, target);
  endtask

  task automatic run_frames(input int n);
    tx_enable = 1'b1;
    wait_frames(n, 60 * n + 40);
    tx_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0;
    int a0;
    int h0;
    int f0;
    int s0;
    reset_rx     = 1'b1;
    tx_enable    = 1'b0;
    frame_format = 3'd1;
    status_in    = 2'd0;
    ser_valid    = 1'b0;
    ser_id       = 4'h0;
    ser_data     = 8'h00;
    nib_ready    = 1'b1;
    repeat (3) @(negedge clk_rx);
    #2;
    check_output("reset_outputs", {21'd0, fifo_rd_en, nib_valid, nib_type, nib_data, frame_done,
                                   ser_msg_done, fmt_err}, 32'd0);
    @(negedge clk_rx);
    reset_rx = 1'b0;
    repeat (2) @(negedge clk_rx);

    // All-zero format-1 frame.
    apply_stimulus(3'd1, 2'd0);
    push_word(12'h000);
    push_word(12'h000);
    expect_frame(4'h0, 24'h000000, 6, 4'h5);
    r0 = rd_cnt;
    run_frames(1);
    check_output("f1_zero_pops", rd_cnt - r0, 2);
    check_output("f1_zero_drained", exp_q.size(), 0);

    apply_stimulus(3'd1, 2'd2);
    push_word(12'hABC);
    push_word(12'h123);
    expect_frame(4'h2, 24'hABC321, 6, 4'h2);
    run_frames(1);

    apply_stimulus(3'd7, 2'd1);
    push_word(12'hABC);
    push_word(12'h123);
    expect_frame(4'h1, 24'hABC132, 6, 4'hB);
    run_frames(1);

    apply_stimulus(3'd2, 2'd3);
    push_word(12'h7E5);
    expect_frame(4'h3, 24'h7E5000, 3, 4'hF);
    r0 = rd_cnt;
    run_frames(1);
    check_output("f2_pops", rd_cnt - r0, 1);

    // Backpressure: hold nib_ready low while D2 is presented.
    apply_stimulus(3'd1, 2'd0);
    push_word(12'hABC);
    push_word(12'h123);
    expect_frame(4'h0, 24'hABC321, 6, 4'h2);
    a0 = acc_cnt;
    h0 = hold_cnt;
    tx_enable = 1'b1;
    wait_acc(a0 + 4, 100);
    @(negedge clk_rx);
    nib_ready = 1'b0;
    repeat (6) @(negedge clk_rx);
    nib_ready = 1'b1;
    wait_frames(1, 100);
    tx_enable = 1'b0;
    check_output("hold_cycles", hold_cnt - h0, 5);

    // FIFO runs dry between W0 and W1: no nibble may appear until W1 arrives.
    apply_stimulus(3'd1, 2'd0);
    push_word(12'hABC);
    expect_frame(4'h0, 24'hABC321, 6, 4'h2);
    a0 = acc_cnt;
    r0 = rd_cnt;
    tx_enable = 1'b1;
    repeat (30) @(negedge clk_rx);
    #2;
    check_output("stall_no_nibble", acc_cnt - a0, 0);
    check_output("stall_one_pop", rd_cnt - r0, 1);
    push_word(12'h123);
    wait_frames(1, 100);
    tx_enable = 1'b0;
    check_output("stall_total_pops", rd_cnt - r0, 2);

    // Illegal format.
    apply_stimulus(3'd5, 2'd0);
    push_word(12'h555);
    r0 = rd_cnt;
    tx_enable = 1'b1;
    repeat (5) @(negedge clk_rx);
    #2;
    check_output("fmt_err_set", 32'(fmt_err), 32'd1);
    check_output("fmt_err_no_pop", rd_cnt - r0, 0);
    tx_enable = 1'b0;
    @(negedge clk_rx);
    wr_ptr = rd_ptr;

    // Reset while D1 is on the bus.
    apply_stimulus(3'd1, 2'd0);
    push_word(12'h000);
    push_word(12'h000);
    exp_q.push_back(nib_t'({2'd0, 4'h0}));
    exp_q.push_back(nib_t'({2'd1, 4'h0}));
    exp_q.push_back(nib_t'({2'd1, 4'h0}));
    exp_q.push_back(nib_t'({2'd1, 4'h0}));
    a0 = acc_cnt;
    tx_enable = 1'b1;
    wait_acc(a0 + 3, 100);
    @(negedge clk_rx);
    @(negedge clk_rx);
    #3;
    check_output("pre_reset_state", {30'd0, nib_valid, fmt_err}, {30'd0, 2'b11});
    reset_rx = 1'b1;
    #1;
    check_output("reset_async", {21'd0, fifo_rd_en, nib_valid, nib_type, nib_data, frame_done,
                                 ser_msg_done, fmt_err}, 32'd0);
    tx_enable = 1'b0;
    repeat (2) @(negedge clk_rx);
    wr_ptr = rd_ptr;
    reset_rx = 1'b0;
    @(negedge clk_rx);
    check_output("reset_drained", exp_q.size(), 0);

    // Clean frame after the abandoned one.
    apply_stimulus(3'd2, 2'd0);
    push_word(12'h7E5);
    expect_frame(4'h0, 24'h7E5000, 3, 4'hF);
    run_frames(1);

    // 16-frame short serial message: ID 0x3, data 0xA5, serial CRC 0x3.
    @(negedge clk_rx);
    reset_rx = 1'b1;
    @(negedge clk_rx);
    reset_rx = 1'b0;
    @(negedge clk_rx);
    apply_stimulus(3'd2, 2'd0);
    ser_valid = 1'b1;
    ser_id    = 4'h3;
    ser_data  = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      push_word(12'h000);
      expect_frame({k == 0, ser_bits[15-k], 2'b00}, 24'h000000, 3, 4'h9);
    end
    f0 = fd_cnt;
    s0 = smd_cnt;
    run_frames(16);
    ser_valid = 1'b0;
    repeat (3) @(negedge clk_rx);
    #2;
    check_output("ser_msg_done_count", smd_cnt - s0, 1);
    check_output("ser_msg_done_frame", smd_at, f0 + 16);
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sent_tx_frame_builder.md
Name: sent_tx_frame_builder

Overview:
Transmit-side SENT (SAE J2716) frame sequencer and the counterpart of the RX control path. It pops 12-bit fast-channel words from the TX FIFO and packs them into data nibbles according to the frame format. It computes the CRC4, inserts the short-serial-message slow-channel bits into the status nibble, and streams typed nibbles (sync/status/data/CRC/pause) to the downstream tick/pulse generator over a valid/ready handshake.

Parameters:
PAUSE_EN, 1, 1 = emit a pause nibble after the CRC nibble of every frame.
CRC_SEED, 4'b0101, initial value of the data and serial CRC4.

Ports:
clk_rx  in  1  clock; all logic on posedge.
reset_rx  in  1  asynchronous, active-high reset.
tx_enable  in  1  allows new frames to start.
frame_format  in  3  1=12/12, 2=one 12-bit, 7=16/8; any other value is illegal.
status_in  in  2  status nibble bits [1:0].
fifo_empty  in  1  TX FIFO empty.
fifo_rd_en  out  1  pop strobe, one cycle.
fifo_rd_data  in  12  word, valid the cycle after fifo_rd_en.
ser_valid  in  1  serial message available.
ser_id  in  4  short serial message ID.
ser_data  in  8  short serial message data.
nib_valid  out  1  nibble valid.
nib_ready  in  1  downstream accepts the nibble.
nib_type  out  2  0=sync, 1=status/data, 2=CRC, 3=pause.
nib_data  out  4  nibble value; 0 for sync and pause.
frame_done  out  1  one-cycle pulse when the last nibble of a frame is accepted.
ser_msg_done  out  1  one-cycle pulse when frame 15 of a serial message completes.
fmt_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; serial frame counter = 0; serial shift register = 0.
- FSM: IDLE -> FETCH -> WAITRD -> (FETCH again for a second word) -> CRC -> SYNC -> STATUS -> DATA -> CRCN -> [PAUSE] -> IDLE.
- IDLE:
  - Leaves IDLE when tx_enable=1 and fifo_empty=0.
  - frame_format is sampled here and held for the whole frame.
  - An illegal format sets fmt_err, pops nothing, and the FSM stays in IDLE.
- Word count: formats 1 and 7 need two words (W0, W1); format 2 needs one (W0).
- FETCH: asserts fifo_rd_en for exactly one cycle, and only when fifo_empty=0; otherwise it stalls in FETCH. No partial frame is ever emitted.
- WAITRD: captures fifo_rd_data.
- Nibble packing, D0 first:
  - Format 1: D0..D2 = W0[11:8], W0[7:4], W0[3:0]; D3..D5 = W1[3:0], W1[7:4], W1[11:8].
  - Format 7: D0..D2 as format 1; D3..D5 = W1[11:8], W1[3:0], W1[7:4].
  - Format 2: D0..D2 only (3 data nibbles).
- Data CRC:
  - Covers data nibbles only, MSB first, bit-serial polynomial x^4+x^3+x^2+1: fb = crc[3]^bit; crc = {crc[2:0],1'b0} ^ (fb ? 4'hD : 0).
  - Seed is CRC_SEED, followed by one augmenting zero nibble.
  - One nibble per cycle in the CRC state, so (N+1) cycles.
- Status nibble:
  - bits [1:0] = status_in sampled in IDLE.
  - bit 3 = 1 only in serial frame 0 while a message is active.
  - bit 2 = current serial bit.
  - With no active message, bits [3:2] = 0.
- Serial message:
  - At the start of serial frame 0, if ser_valid=1, latch the 16-bit message {ser_id, ser_data, scrc}.
  - scrc = CRC4 over the 3 nibbles ser_id, ser_data[7:4], ser_data[3:0], using the same seed, polynomial and augmentation.
  - One bit is sent per frame, MSB first; the counter increments on each frame_done and wraps 15 -> 0.
  - ser_msg_done pulses on frame 15's frame_done, and only if a message was active.
  - If ser_valid=0 at frame 0, that 16-frame window carries no message.
- Handshake:
  - nib_valid, nib_type and nib_data stay stable until the cycle with nib_ready=1.
  - The next nibble is presented on the following cycle, so at most one nibble per two cycles.
  - nib_ready is ignored while nib_valid=0.
- frame_done pulses in the cycle after the final accepted nibble (CRC, or PAUSE if PAUSE_EN).
- tx_enable deasserted mid-frame: the current frame completes, then the FSM stays in IDLE.
- frame_format changing mid-frame has no effect on the current frame.
- Latency: with the FIFO non-empty and nib_ready=1, the SYNC nibble is valid ≤ 12 cycles after IDLE exit.
- Reset mid-frame: all outputs drop in the same cycle (asynchronous); the frame is abandoned and already-popped words are discarded.

Test Plan:
- Format 1, words 0x000/0x000, status_in=0, ser_valid=0 -> nibble sequence sync, status 0, six data 0s, CRC 0x5, pause; 2 pops; one frame_done.
- Format 1, words 0xABC/0x123 -> data nibbles A, B, C, 3, 2, 1; CRC matches the bit-serial model. Format 7 with the same words -> A, B, C, 1, 3, 2.
- Format 2, word 0x7E5 -> exactly 1 pop; data nibbles 7, E, 5; CRC nibble follows D2.
- ser_valid=1, ser_id=0x3, ser_data=0xA5 over 16 frames:
  - status bit 3 = 1 in frame 0 only;
  - status bit 2 sequence = 0,0,1,1, 1,0,1,0, 0,1,0,1, then the 4 scrc bits;
  - ser_msg_done after frame 15.
- nib_ready held low 5 cycles during D2 -> nib_data/nib_type stable throughout. FIFO empty between W0 and W1 -> FSM stalls in FETCH and no SYNC is emitted.
- frame_format=5 -> fmt_err=1, no fifo_rd_en. reset_rx asserted mid-DATA -> all outputs 0 immediately; the next frame starts cleanly with SYNC.
